store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 128 ++++++++++++
 tb/tb_store_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port data memory.
// Queues lane-aligned stores and drains them in order when loads are idle.
//
// Parameters:
//   DEPTH     pending-store entries (power of two, >= 2)
//   ADDR_W    data-memory word-address width
// Ports:
//   clk, rst                      clock, sync active-high reset
//   st_valid/st_addr/st_data/
//   st_wmask, st_ready            store request and accept
//   ld_valid/ld_addr, ld_stall    load request and RAW hazard stall
//   dm_en/dm_we/dm_addr/dm_wdata  data-memory port
//   empty                         no pending stores
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [3:0]        st_wmask,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_stall,
  output logic              dm_en,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [3:0]        mask_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic [DEPTH-1:0] match;
  logic             push;
  logic             pop;
  logic             load_go;

  // Only buffered entries are compared; the store arriving this
  // cycle is not yet visible to the hazard check.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (addr_q[i] == ld_addr);
    end
  end

  assign ld_stall = ld_valid & (|match);
  assign st_ready = (count != CNT_FULL);
  assign empty    = (count == '0);

  assign push    = st_valid & st_ready & (|st_wmask);
  assign load_go = ld_valid & ~ld_stall;
  // A stalled load does not own the port, so the head keeps
  // draining and the hazard clears within DEPTH cycles.
  assign pop     = ~load_go & (count != '0);

  always_comb begin
    dm_en    = 1'b0;
    dm_we    = 4'b0000;
    dm_addr  = '0;
    dm_wdata = '0;
    unique case (1'b1)
      load_go: begin
        dm_en   = 1'b1;
        dm_addr = ld_addr;
      end
      pop: begin
        dm_en    = 1'b1;
        dm_we    = mask_q[head];
        dm_addr  = addr_q[head];
        dm_wdata = data_q[head];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      // Push and pop never target the same slot: pop needs
      // count > 0 and push needs count < DEPTH.
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_ONE;
      end
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
      mask_q[tail] <= st_wmask;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table plus randomized
// traffic checked against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [3:0]        st_wmask;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_stall;
  logic              dm_en;
  logic [3:0]        dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              empty;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_wmask(st_wmask),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_stall(ld_stall),
    .dm_en(dm_en), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sv;
    logic [9:0]  sa;
    logic [31:0] sd;
    logic [3:0]  sm;
    logic        lv;
    logic [9:0]  la;
    logic        e_rdy;
    logic        e_stall;
    logic        e_en;
    logic [3:0]  e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    logic        e_empty;
  } vec_t;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  vec_t tbl[$];
  ent_t q[$];
  int checks;
  int failures;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic sv, input int sa,
                     input int sm, input logic lv, input int la,
                     input logic rdy, input logic stl, input logic en,
                     input int we, input int ea, input int ed,
                     input logic emp);
    vec_t v;
    v.rst = r;  v.sv = sv; v.sa = 10'(sa);
    v.sd = 32'hD000_0000 | 32'(sa);
    v.sm = 4'(sm); v.lv = lv; v.la = 10'(la);
    v.e_rdy = rdy; v.e_stall = stl; v.e_en = en;
    v.e_we = 4'(we); v.e_addr = 10'(ea);
    v.e_data = 32'(ed); v.e_empty = emp;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] dv(input int a);
    return 32'hD000_0000 | 32'(a);
  endfunction

  task automatic drive(input logic r, input logic sv,
                       input logic [9:0] sa, input logic [31:0] sd,
                       input logic [3:0] sm, input logic lv,
                       input logic [9:0] la);
    rst = r; st_valid = sv; st_addr = sa; st_data = sd;
    st_wmask = sm; ld_valid = lv; ld_addr = la;
  endtask

  task automatic cmp_all(input string t, input logic rdy,
                         input logic stl, input logic en,
                         input logic [3:0] we, input logic [9:0] a,
                         input logic [31:0] d, input logic emp);
    chk({t, ".st_ready"}, 32'(st_ready), 32'(rdy));
    chk({t, ".ld_stall"}, 32'(ld_stall), 32'(stl));
    chk({t, ".dm_en"},    32'(dm_en),    32'(en));
    chk({t, ".dm_we"},    32'(dm_we),    32'(we));
    chk({t, ".dm_addr"},  32'(dm_addr),  32'(a));
    chk({t, ".dm_wdata"}, dm_wdata,      d);
    chk({t, ".empty"},    32'(empty),    32'(emp));
  endtask

  logic [3:0] masks [8];

  initial begin
    checks = 0;
    failures = 0;
    masks = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h0};
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;

    // post-reset idle
    add(0,0,0,0, 0,0,   1,0,0,0,0,0,1);
    // fill with drain held off by a non-matching load
    add(0,1,'h10,'hF, 1,'h3F, 1,0,1,0,'h3F,0,1);
    add(0,1,'h11,'hF, 1,'h3F, 1,0,1,0,'h3F,0,0);
    add(0,1,'h12,'hF, 1,'h3F, 1,0,1,0,'h3F,0,0);
    add(0,1,'h13,'hF, 1,'h3F, 1,0,1,0,'h3F,0,0);
    add(0,1,'h14,'hF, 1,'h3F, 0,0,1,0,'h3F,0,0);
    add(0,0,0,0, 0,0, 0,0,1,'hF,'h10,dv('h10),0);
    add(0,0,0,0, 0,0, 1,0,1,'hF,'h11,dv('h11),0);
    add(0,0,0,0, 0,0, 1,0,1,'hF,'h12,dv('h12),0);
    add(0,0,0,0, 0,0, 1,0,1,'hF,'h13,dv('h13),0);
    add(0,0,0,0, 0,0, 1,0,0,0,0,0,1);
    // RAW hazard: one stall cycle while the store drains
    add(0,1,'h20,'hC, 0,0, 1,0,0,0,0,0,1);
    add(0,0,0,0, 1,'h20, 1,1,1,'hC,'h20,dv('h20),0);
    add(0,0,0,0, 1,'h20, 1,0,1,0,'h20,0,1);
    add(0,0,0,0, 0,0, 1,0,0,0,0,0,1);
    // non-matching load owns the port, drain deferred
    add(0,1,'h05,'hF, 0,0, 1,0,0,0,0,0,1);
    add(0,0,0,0, 1,'h06, 1,0,1,0,'h06,0,0);
    add(0,0,0,0, 1,'h06, 1,0,1,0,'h06,0,0);
    add(0,0,0,0, 0,0, 1,0,1,'hF,'h05,dv('h05),0);
    add(0,0,0,0, 0,0, 1,0,0,0,0,0,1);
    // concurrent push/pop at count 2, pointers wrap
    add(0,1,'h30,'hF, 1,'h3F, 1,0,1,0,'h3F,0,1);
    add(0,1,'h31,'h3, 1,'h3F, 1,0,1,0,'h3F,0,0);
    add(0,1,'h32,'hF, 0,0, 1,0,1,'hF,'h30,dv('h30),0);
    add(0,1,'h33,'hF, 0,0, 1,0,1,'h3,'h31,dv('h31),0);
    add(0,1,'h34,'hF, 0,0, 1,0,1,'hF,'h32,dv('h32),0);
    add(0,1,'h35,'hF, 0,0, 1,0,1,'hF,'h33,dv('h33),0);
    add(0,1,'h36,'h8, 0,0, 1,0,1,'hF,'h34,dv('h34),0);
    add(0,1,'h37,'hF, 0,0, 1,0,1,'hF,'h35,dv('h35),0);
    add(0,0,0,0, 0,0, 1,0,1,'h8,'h36,dv('h36),0);
    add(0,0,0,0, 0,0, 1,0,1,'hF,'h37,dv('h37),0);
    add(0,0,0,0, 0,0, 1,0,0,0,0,0,1);
    // zero-mask store is dropped
    add(0,1,'h40,'h0, 0,0, 1,0,0,0,0,0,1);
    add(0,0,0,0, 0,0, 1,0,0,0,0,0,1);
    // reset with three pending entries
    add(0,1,'h50,'hF, 1,'h3F, 1,0,1,0,'h3F,0,1);
    add(0,1,'h51,'hF, 1,'h3F, 1,0,1,0,'h3F,0,0);
    add(0,1,'h52,'hF, 1,'h3F, 1,0,1,0,'h3F,0,0);
    add(1,0,0,0, 1,'h3F, 1,0,1,0,'h3F,0,0);
    add(0,0,0,0, 0,0, 1,0,0,0,0,0,1);
    add(0,0,0,0, 1,'h50, 1,0,1,0,'h50,0,1);
    add(0,0,0,0, 0,0, 1,0,0,0,0,0,1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].sv, tbl[i].sa, tbl[i].sd,
            tbl[i].sm, tbl[i].lv, tbl[i].la);
      #4;
      cmp_all($sformatf("vec%0d", i), tbl[i].e_rdy,
              tbl[i].e_stall, tbl[i].e_en, tbl[i].e_we,
              tbl[i].e_addr, tbl[i].e_data, tbl[i].e_empty);
      @(posedge clk);
      #1;
    end

    // randomized traffic against the queue model
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic r, sv, lv, stl, rdy, lgo, drn, psh;
      logic [9:0] sa, la, ea;
      logic [31:0] sd, ed;
      logic [3:0] sm, ewe;
      r  = ($urandom_range(0, 99) == 0);
      sv = $urandom_range(0, 1) == 1;
      lv = $urandom_range(0, 2) == 0;
      sa = 10'($urandom_range(0, 7));
      la = 10'($urandom_range(0, 7));
      sd = $urandom;
      sm = masks[$urandom_range(0, 7)];
      rdy = (q.size() != DEPTH);
      stl = 1'b0;
      foreach (q[k]) if (lv && q[k].a == la) stl = 1'b1;
      lgo = lv && !stl;
      drn = !lgo && (q.size() != 0);
      psh = sv && rdy && (sm != 4'h0);
      ewe = 4'h0; ea = '0; ed = '0;
      if (lgo) ea = la;
      else if (drn) begin
        ewe = q[0].m; ea = q[0].a; ed = q[0].d;
      end
      drive(r, sv, sa, sd, sm, lv, la);
      #4;
      cmp_all($sformatf("rnd%0d", n), rdy, stl, lgo || drn,
              ewe, ea, ed, q.size() == 0);
      @(posedge clk);
      if (r) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (psh) q.push_back('{a: sa, d: sd, m: sm});
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
